// File: rtl/text_pixel_pipe_if.sv
// Text RAM / font ROM read bus of the text pixel pipe.
// Both memories return data combinationally from the registered address.
interface text_pixel_pipe_if #(
  parameter int TA_W = 8,
  parameter int TD_W = 16,
  parameter int FA_W = 12,
  parameter int FR_W = 8
);
  logic            txt_rd_o;
  logic [TA_W-1:0] txt_addr_o;
  logic [TD_W-1:0] txt_data_i;
  logic            font_rd_o;
  logic [FA_W-1:0] font_addr_o;
  logic [FR_W-1:0] font_row_i;

  modport master (
    output txt_rd_o, txt_addr_o,
    output font_rd_o, font_addr_o,
    input  txt_data_i, font_row_i
  );

  modport slave (
    input  txt_rd_o, txt_addr_o,
    input  font_rd_o, font_addr_o,
    output txt_data_i, font_row_i
  );
endinterface

// File: rtl/text_pixel_pipe.sv
// Text-mode pixel generator: coordinate -> char cell -> glyph bit,
// fixed 3-cycle latency with blinking cursor overlay.
module text_pixel_pipe #(
  parameter int COLS         = 64,
  parameter int ROWS         = 4,
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 16,
  parameter int CHAR_W       = 8,
  parameter int COLOR_W      = 4,
  parameter int COORD_W      = 11,
  parameter int BLINK_FRAMES = 30,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid_i,
  input  logic [COORD_W-1:0] horz_i,
  input  logic [COORD_W-1:0] vert_i,
  input  logic               frame_start_i,
  input  logic [COORD_W-1:0] win_x_i,
  input  logic [COORD_W-1:0] win_y_i,
  input  logic               enable_i,
  input  logic               cursor_en_i,
  input  logic [COL_W-1:0]   cursor_col_i,
  input  logic [ROW_W-1:0]   cursor_row_i,
  text_pixel_pipe_if.master  mem,
  output logic               pix_valid_o,
  output logic               pix_on_o,
  output logic [COLOR_W-1:0] color_o
);
  localparam int FX_W = $clog2(FONT_W);
  localparam int FY_W = $clog2(FONT_H);
  localparam int CELLS = COLS * ROWS;
  localparam int TA_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int XW = COORD_W + 1;
  localparam int BC_W =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if ((FONT_W & (FONT_W - 1)) != 0) begin : g_fw_chk
    $error("FONT_W must be a power of 2");
  end
  if ((FONT_H & (FONT_H - 1)) != 0) begin : g_fh_chk
    $error("FONT_H must be a power of 2");
  end

  logic signed [XW-1:0] w_rx;
  logic signed [XW-1:0] w_ry;
  logic                 w_inwin;
  logic                 w_act;
  logic                 w_hit;
  logic [COL_W-1:0]     w_col;
  logic [ROW_W-1:0]     w_row;
  logic [FX_W-1:0]      w_bx;
  logic [FY_W-1:0]      w_gy;
  logic [TA_W-1:0]      w_taddr;

  logic [BC_W-1:0]      r_bcnt;
  logic                 r_phase;

  logic                 r_v1, r_a1, r_inv1;
  logic [FX_W-1:0]      r_bx1;
  logic [FY_W-1:0]      r_gy1;
  logic                 r_v2, r_a2, r_inv2;
  logic [FX_W-1:0]      r_bx2;
  logic [2*COLOR_W-1:0] r_attr2;

  logic [FX_W-1:0]      w_sel;
  logic                 w_on;
  logic [COLOR_W-1:0]   w_fg, w_bg;

  assign w_rx = $signed({1'b0, horz_i})
              - $signed({1'b0, win_x_i});
  assign w_ry = $signed({1'b0, vert_i})
              - $signed({1'b0, win_y_i});

  // sign bit clear means the coordinate is at or past the edge
  assign w_inwin =
    !w_rx[XW-1] && !w_ry[XW-1] &&
    ({1'b0, w_rx[XW-2:0]} < XW'(COLS * FONT_W)) &&
    ({1'b0, w_ry[XW-2:0]} < XW'(ROWS * FONT_H));

  assign w_col = w_rx[FX_W +: COL_W];
  assign w_row = w_ry[FY_W +: ROW_W];
  assign w_bx  = w_rx[FX_W-1:0];
  assign w_gy  = w_ry[FY_W-1:0];
  assign w_act = pix_valid_i & w_inwin & enable_i;

  assign w_hit = cursor_en_i & r_phase &
                 (w_col == cursor_col_i) &
                 (w_row == cursor_row_i);

  assign w_taddr = TA_W'(w_row) * TA_W'(COLS)
                 + TA_W'(w_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (frame_start_i) begin
      if (r_bcnt == BC_W'(BLINK_FRAMES - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1           <= 1'b0;
      r_a1           <= 1'b0;
      r_inv1         <= 1'b0;
      r_bx1          <= '0;
      r_gy1          <= '0;
      mem.txt_rd_o   <= 1'b0;
      mem.txt_addr_o <= '0;
    end else begin
      r_v1         <= pix_valid_i;
      r_a1         <= w_act;
      r_inv1       <= w_hit;
      r_bx1        <= w_bx;
      r_gy1        <= w_gy;
      mem.txt_rd_o <= w_act;
      if (w_act) mem.txt_addr_o <= w_taddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2            <= 1'b0;
      r_a2            <= 1'b0;
      r_inv2          <= 1'b0;
      r_bx2           <= '0;
      r_attr2         <= '0;
      mem.font_rd_o   <= 1'b0;
      mem.font_addr_o <= '0;
    end else begin
      r_v2          <= r_v1;
      r_a2          <= r_a1;
      r_inv2        <= r_inv1;
      r_bx2         <= r_bx1;
      r_attr2       <= mem.txt_data_i[CHAR_W +: 2*COLOR_W];
      mem.font_rd_o <= r_a1;
      if (r_a1) begin
        mem.font_addr_o <=
          {mem.txt_data_i[CHAR_W-1:0], r_gy1};
      end
    end
  end

  // MSB of the glyph row is the leftmost pixel
  assign w_sel = FX_W'(FONT_W - 1) - r_bx2;
  assign w_on  = r_a2 & (mem.font_row_i[w_sel] ^ r_inv2);
  assign w_fg  = r_attr2[COLOR_W-1:0];
  assign w_bg  = r_attr2[2*COLOR_W-1:COLOR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_o <= 1'b0;
      pix_on_o    <= 1'b0;
      color_o     <= '0;
    end else begin
      pix_valid_o <= r_v2;
      pix_on_o    <= w_on;
      if (!r_a2)     color_o <= '0;
      else if (w_on) color_o <= w_fg;
      else           color_o <= w_bg;
    end
  end
endmodule

// File: doc/text_pixel_pipe.md
Name: text_pixel_pipe

Overview:
- Parametrised text-mode pixel generator for the VGA text path.
- Maps each incoming screen coordinate to a character cell in a COLS x ROWS window placed at (win_x_i, win_y_i).
- Fetches the character code and attribute from an external text RAM, then the glyph row from an external font ROM.
- Emits the pixel's on/off state and colour index through a fixed-latency, fully pipelined path with a blinking cursor overlay.

Parameters:
COLS, 64, character columns in window
ROWS, 4, character rows in window
FONT_W, 8, glyph width in pixels (power of 2)
FONT_H, 16, glyph height in pixels (power of 2)
CHAR_W, 8, character code width
COLOR_W, 4, colour index width; attribute = {bg[COLOR_W-1:0], fg[COLOR_W-1:0]}
COORD_W, 11, screen coordinate width (unsigned)
BLINK_FRAMES, 30, frames per cursor blink phase

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pix_valid_i  in  1  coordinate valid this cycle
horz_i  in  COORD_W  horizontal coordinate
vert_i  in  COORD_W  vertical coordinate
frame_start_i  in  1  one-cycle pulse per frame
win_x_i  in  COORD_W  window left edge
win_y_i  in  COORD_W  window top edge
enable_i  in  1  text layer enable
cursor_en_i  in  1  cursor overlay enable
cursor_col_i  in  clog2(COLS)  cursor column
cursor_row_i  in  clog2(ROWS)  cursor row
txt_rd_o  out  1  text RAM read strobe
txt_addr_o  out  clog2(COLS*ROWS)  text RAM address = row*COLS+col
txt_data_i  in  CHAR_W+2*COLOR_W  {attr, code}; valid 1 cycle after txt_rd_o
font_rd_o  out  1  font ROM read strobe
font_addr_o  out  CHAR_W+clog2(FONT_H)  code*FONT_H + glyph row
font_row_i  in  FONT_W  glyph row bits, MSB = leftmost; valid 1 cycle after font_rd_o
pix_valid_o  out  1  output pixel valid
pix_on_o  out  1  foreground pixel
color_o  out  COLOR_W  colour index

Behaviour:
- Reset: all outputs 0; pipeline valid bits 0; blink counter 0; blink phase 1 (cursor visible).
- There is no backpressure. Every cycle advances the pipeline. Bubbles (pix_valid_i=0) propagate as pix_valid_o=0.
- Stage S0 (input cycle):
  - rx = horz_i - win_x_i and ry = vert_i - win_y_i, computed COORD_W+1 bits signed.
  - inwin = rx>=0 && rx<COLS*FONT_W && ry>=0 && ry<ROWS*FONT_H.
  - col = rx/FONT_W, row = ry/FONT_H, gy = ry%FONT_H, bx = rx%FONT_W; bit slicing only.
  - txt_rd_o = pix_valid_i & inwin & enable_i (registered, with txt_addr_o, at the S0->S1 edge).
- Stage S1: txt_data_i captured. font_rd_o and font_addr_o are driven (registered) with code*FONT_H+gy. Attr, bx, cursor-hit and inwin are delayed alongside.
- Stage S2: font_row_i captured. Bit selected = font_row_i[FONT_W-1-bx].
- Output register, latency exactly 3 cycles from pix_valid_i to pix_valid_o:
  - pix_valid_o = delayed pix_valid_i.
  - If not (inwin & enable_i): pix_on_o=0, color_o=0.
  - Otherwise let inv = cursor_en_i & blink phase & (col==cursor_col_i) & (row==cursor_row_i), sampled at S0.
  - pix_on_o = bit XOR inv.
  - color_o = pix_on_o ? fg : bg.
- No memory strobes are issued for out-of-window, disabled or invalid pixels. The address outputs hold their last value.
- Blink:
  - The counter increments on each frame_start_i.
  - When the counter reaches BLINK_FRAMES-1 and frame_start_i is seen, the phase toggles and the counter returns to 0.
  - frame_start_i concurrent with pix_valid_i is legal. The phase change affects pixels entering S0 in the next cycle.
- Cursor coordinates outside the window range never match.
- Asynchronous reset mid-frame clears valids immediately. The first valid output comes 3 cycles after the first pix_valid_i after release.
- Elaboration error if FONT_W or FONT_H is not a power of 2.

Test Plan:
- Reset/latency:
  - Stimulus: assert rst_n=0 mid-stream; then release with win=(0,0), text[0]={attr 8'h1F, code 8'h41} and font row 0 of 'A' = 8'b00011000; drive horz=3, vert=0.
  - Response: all outputs 0 during reset; after release, txt_addr_o=0, font_addr_o=0x410, and 3 cycles later pix_valid_o=1, pix_on_o=1, color_o=0xF.
- Bit order/background:
  - Stimulus: same cell, horz=0.
  - Response: pix_on_o=0, color_o=0x1. Scan of horz 0..7 yields 00011000.
- Window bounds:
  - Stimulus: win=(100,50); drive horz=99, 100, 611, 612 at vert=50, plus vert=113 and vert=114.
  - Response: only horz=100 and 611 with vert in 50..113 produce txt_rd_o. Outside points give pix_on_o=0, color_o=0 and no strobes.
- Cursor blink:
  - Stimulus: BLINK_FRAMES=2, cursor at (5,1), enable on; sample the cell pixel across 4 frame_start_i pulses.
  - Response: inverted for frames 0-1, normal for frames 2-3, inverted from frame 4.
- Throughput/bubbles:
  - Stimulus: back-to-back 64 valid pixels with pix_valid_i dropped every 3rd cycle.
  - Response: output valids mirror the input pattern delayed 3 cycles; no pixel lost or duplicated.
- Disable:
  - Stimulus: enable_i=0 on in-window pixels.
  - Response: pix_valid_o still asserted, pix_on_o=0, color_o=0, txt_rd_o=font_rd_o=0.
